// File: rtl/async_fifo_param.sv
// async_fifo_param: parametrised dual-clock FIFO (wclk producer, rclk consumer).
// Gray-coded pointers cross domains through SYNC_STAGES-flop synchronisers.
// Storage is a plain register array. Each side derives its flags and occupancy
// level from its own registered pointer and the synchronised remote pointer.
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through reads.
// When it is undefined, reads are standard registered pops.
`timescale 1ns/1ps
module async_fifo_param #(
  parameter int WIDTH       = 16,
  parameter int DEPTH_LOG2  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic                  rclk,
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [DEPTH_LOG2:0]   wlevel,
  output logic                  woverflow,
  input  logic                  rinc,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [DEPTH_LOG2:0]   rlevel,
  output logic                  runderflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  // A pointer exactly one lap ahead differs in the two top Gray bits only.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0]                   wbin_reg, wgray_reg, wbin_next;
  logic [SYNC_STAGES-1:0][PW-1:0]  rsync_pipe_reg;
  logic [PW-1:0]                   rsync, rbin_sync;
  logic                            woverflow_reg, wr_en;

  // ---------------- read domain -----------------
  logic [PW-1:0]                   rbin_reg, rgray_reg, rbin_next;
  logic [SYNC_STAGES-1:0][PW-1:0]  wsync_pipe_reg;
  logic [PW-1:0]                   wsync, wbin_sync;
  logic [WIDTH-1:0]                rdata_reg;
  logic                            rvalid_reg, runderflow_reg;
  logic                            store_empty, pop, underflow_evt;

  assign wbin_next = wbin_reg + PW'(1);
  assign rsync     = rsync_pipe_reg[SYNC_STAGES-1];
  assign rbin_sync = gray2bin(rsync);
  assign wfull     = (wgray_reg == (rsync ^ FULL_MASK));
  assign wr_en     = winc && !wfull;
  // Stale read pointer only makes this over-report, never under-report.
  assign wlevel       = wbin_reg - rbin_sync;
  assign walmost_full = (wlevel >= PW'(AFULL_TH));
  assign woverflow    = woverflow_reg;

  // Store accepted words; contents are deliberately left alone by reset.
  always_ff @(posedge wclk) begin
    if (wr_en) begin
      mem[wbin_reg[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  // Advance the write pointer and latch overflow on a dropped write.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_reg      <= '0;
      wgray_reg     <= '0;
      woverflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wbin_reg  <= wbin_next;
        wgray_reg <= bin2gray(wbin_next);
      end
      if (winc && wfull) begin
        woverflow_reg <= 1'b1;
      end
    end
  end

  // Bring the read Gray pointer into the write clock domain.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rsync_pipe_reg <= '0;
    end else begin
      rsync_pipe_reg <= {rsync_pipe_reg[SYNC_STAGES-2:0], rgray_reg};
    end
  end

  // Bring the write Gray pointer into the read clock domain.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      wsync_pipe_reg <= '0;
    end else begin
      wsync_pipe_reg <= {wsync_pipe_reg[SYNC_STAGES-2:0], wgray_reg};
    end
  end

  assign wsync       = wsync_pipe_reg[SYNC_STAGES-1];
  assign wbin_sync   = gray2bin(wsync);
  assign rbin_next   = rbin_reg + PW'(1);
  assign store_empty = (rgray_reg == wsync);

`ifdef FIFO_FWFT_EN
  // Prefetch register refills whenever it is empty or being consumed.
  assign pop           = !store_empty && (!rvalid_reg || rinc);
  assign underflow_evt = rinc && !rvalid_reg;
  assign rempty        = !rvalid_reg;
  assign rlevel        = wbin_sync - rbin_reg + PW'(rvalid_reg);
`else
  assign pop           = rinc && !store_empty;
  assign underflow_evt = rinc && store_empty;
  assign rempty        = store_empty;
  // Stale write pointer only makes this under-report, never over-report.
  assign rlevel        = wbin_sync - rbin_reg;
`endif

  assign ralmost_empty = (rlevel <= PW'(AEMPTY_TH));
  assign rdata         = rdata_reg;
  assign rvalid        = rvalid_reg;
  assign runderflow    = runderflow_reg;

  // Advance the read pointer on a pop and latch underflow.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_reg       <= '0;
      rgray_reg      <= '0;
      runderflow_reg <= 1'b0;
    end else begin
      if (pop) begin
        rbin_reg  <= rbin_next;
        rgray_reg <= bin2gray(rbin_next);
      end
      if (underflow_evt) begin
        runderflow_reg <= 1'b1;
      end
    end
  end

  // Registered read data and its valid qualifier.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      if (pop) begin
        rdata_reg <= mem[rbin_reg[DEPTH_LOG2-1:0]];
      end
`ifdef FIFO_FWFT_EN
      if (pop) begin
        rvalid_reg <= 1'b1;
      end else if (rinc) begin
        rvalid_reg <= 1'b0;
      end
`else
      rvalid_reg <= pop;
`endif
    end
  end

endmodule

// File: tb/tb_async_fifo_param.sv
// Testbench for async_fifo_param: directed boundary tests plus a randomized
// concurrent producer/consumer checked against a queue model.
// Define FIFO_FWFT_EN to exercise the first-word-fall-through build.
`timescale 1ns/1ps
module tb_async_fifo_param;

  localparam int WIDTH  = 16;
  localparam int DL     = 6;
  localparam int DEPTH  = 64;
  localparam int AF_TH  = 60;
  localparam int AE_TH  = 4;
  localparam int N_RND  = 300;

  logic              rclk = 1'b0, wclk = 1'b0, rst_n = 1'b0;
  logic              winc = 1'b0, rinc = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic              wfull, walmost_full, woverflow;
  logic              rvalid, rempty, ralmost_empty, runderflow;
  logic [DL:0]       wlevel, rlevel;
  logic [WIDTH-1:0]  rdata;

  real rhalf = 8.5;
  int  n_cmp = 0, n_err = 0;
  logic [WIDTH-1:0] q [$];
  int  wr_sent, wr_guard, rd_got, rd_guard;
  bit  rd_pend;
  logic [WIDTH-1:0] rd_exp;

  async_fifo_param #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DL), .SYNC_STAGES(2),
    .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
  ) dut (
    .rclk(rclk), .wclk(wclk), .rst_n(rst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow),
    .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 wclk = ~wclk;
  always #(rhalf) rclk = ~rclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string ph);
    check_eq({ph, "_wfull"},         32'(wfull), 0);
    check_eq({ph, "_walmost_full"},  32'(walmost_full), 0);
    check_eq({ph, "_wlevel"},        32'(wlevel), 0);
    check_eq({ph, "_woverflow"},     32'(woverflow), 0);
    check_eq({ph, "_rdata"},         32'(rdata), 0);
    check_eq({ph, "_rvalid"},        32'(rvalid), 0);
    check_eq({ph, "_rempty"},        32'(rempty), 1);
    check_eq({ph, "_ralmost_empty"}, 32'(ralmost_empty), 1);
    check_eq({ph, "_rlevel"},        32'(rlevel), 0);
    check_eq({ph, "_runderflow"},    32'(runderflow), 0);
  endtask

  task automatic do_reset();
    winc = 1'b0;
    rinc = 1'b0;
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge wclk); #1;
  endtask

  // Call at #1 after a wclk edge; returns #1 after the edge that samples it.
  task automatic wr(input logic [WIDTH-1:0] d);
    winc = 1'b1;
    wdata = d;
    @(posedge wclk); #1;
    winc = 1'b0;
  endtask

  task automatic mid_burst_reset();
    do_reset();
    for (int i = 0; i < 8; i++) wr(WIDTH'(16'h0A00 + i));
    repeat (5) @(posedge rclk);
    #1;
    rinc = 1'b1;
    winc = 1'b1;
    wdata = 16'h0B00;
    repeat (3) @(posedge rclk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    rinc = 1'b0;
    winc = 1'b0;
    #5;
    rst_n = 1'b1;
    @(posedge wclk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    do_reset();
    check_reset("rst0");

`ifdef FIFO_FWFT_EN
    wr(16'hBEEF);
    for (k = 0; k < 6; k++) begin
      @(posedge rclk); #1;
      if (rvalid) break;
    end
    check_eq("fwft_latency_ok", 32'(k <= 3), 1);
    check_eq("fwft_rvalid", 32'(rvalid), 1);
    check_eq("fwft_rdata", 32'(rdata), 32'h0000BEEF);
    check_eq("fwft_rempty", 32'(rempty), 0);
    check_eq("fwft_rlevel", 32'(rlevel), 1);
    $display("rd fwft data=0x%04h", rdata);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check_eq("fwft_pop_rvalid", 32'(rvalid), 0);
    check_eq("fwft_pop_rempty", 32'(rempty), 1);
    check_eq("fwft_pop_runderflow", 32'(runderflow), 0);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check_eq("fwft_uf_runderflow", 32'(runderflow), 1);
    check_eq("fwft_uf_rlevel", 32'(rlevel), 0);
`else
    // Underflow on an empty FIFO: flag sets, no pop, pointer untouched.
    @(posedge rclk); #1;
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check_eq("uf_runderflow", 32'(runderflow), 1);
    check_eq("uf_rvalid", 32'(rvalid), 0);
    check_eq("uf_rlevel", 32'(rlevel), 0);
    check_eq("uf_rempty", 32'(rempty), 1);
    do_reset();
    check_reset("rst1");

    // Single word through the FIFO.
    wr(16'h1234);
    for (k = 0; k < 5; k++) begin
      @(posedge rclk); #1;
      if (!rempty) break;
    end
    check_eq("t1_empty_drop_ok", 32'(k <= 2), 1);
    check_eq("t1_rlevel", 32'(rlevel), 1);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    check_eq("t1_rvalid", 32'(rvalid), 1);
    check_eq("t1_rdata", 32'(rdata), 32'h00001234);
    $display("rd t1 data=0x%04h", rdata);
    @(posedge rclk); #1;
    check_eq("t1_rvalid_drop", 32'(rvalid), 0);
    check_eq("t1_rdata_hold", 32'(rdata), 32'h00001234);
    check_eq("t1_rempty", 32'(rempty), 1);

    // Fill to capacity, overflow, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      wr(WIDTH'(i));
      check_eq("fill_wlevel", 32'(wlevel), i + 1);
      check_eq("fill_wfull", 32'(wfull), (i == DEPTH - 1) ? 1 : 0);
      check_eq("fill_afull", 32'(walmost_full), (i + 1 >= AF_TH) ? 1 : 0);
    end
    check_eq("fill_woverflow_pre", 32'(woverflow), 0);
    wr(16'hDEAD);
    check_eq("ovf_woverflow", 32'(woverflow), 1);
    check_eq("ovf_wfull", 32'(wfull), 1);
    check_eq("ovf_wlevel", 32'(wlevel), DEPTH);
    repeat (4) @(posedge rclk);
    #1;
    rinc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_rlevel", 32'(rlevel), DEPTH - i);
      check_eq("drain_aempty", 32'(ralmost_empty), (DEPTH - i <= AE_TH) ? 1 : 0);
      @(posedge rclk); #1;
      if (i == DEPTH - 1) rinc = 1'b0;
      check_eq("drain_rvalid", 32'(rvalid), 1);
      check_eq("drain_rdata", 32'(rdata), i);
      $display("rd drain %0d data=0x%04h", i, rdata);
    end
    check_eq("drain_rempty", 32'(rempty), 1);
    check_eq("drain_rlevel_end", 32'(rlevel), 0);
    check_eq("drain_aempty_end", 32'(ralmost_empty), 1);
    check_eq("drain_runderflow", 32'(runderflow), 0);
    check_eq("drain_woverflow_sticky", 32'(woverflow), 1);
    @(posedge rclk); #1;
    check_eq("drain_rvalid_drop", 32'(rvalid), 0);
    repeat (4) @(posedge wclk);
    #1;
    check_eq("drain_wfull_clear", 32'(wfull), 0);
    check_eq("drain_wlevel_clear", 32'(wlevel), 0);

    // Randomized concurrent traffic with rclk at 7ns.
    @(posedge rclk);
    rhalf = 3.5;
    do_reset();
    q.delete();
    wr_sent = 0; wr_guard = 0; rd_got = 0; rd_guard = 0; rd_pend = 1'b0; rd_exp = '0;
    fork
      begin : writer
        while (wr_sent < N_RND && wr_guard < 20000) begin
          wr_guard++;
          if (!wfull && $urandom_range(0, 3) != 0) begin
            check_eq("rnd_wlevel_ge_model", 32'(int'(wlevel) >= q.size()), 1);
            winc = 1'b1;
            wdata = WIDTH'($urandom);
            q.push_back(wdata);
            wr_sent++;
          end else begin
            winc = 1'b0;
          end
          @(posedge wclk); #1;
        end
        winc = 1'b0;
        check_eq("rnd_wr_done", wr_sent, N_RND);
      end
      begin : reader
        @(posedge rclk); #1;
        while (rd_got < N_RND && rd_guard < 30000) begin
          rd_guard++;
          if (rd_pend) begin
            check_eq("rnd_rvalid", 32'(rvalid), 1);
            check_eq("rnd_rdata", 32'(rdata), 32'(rd_exp));
            $display("rd rnd %0d data=0x%04h exp=0x%04h", rd_got, rdata, rd_exp);
            rd_got++;
          end
          check_eq("rnd_rlevel_le_model", 32'(int'(rlevel) <= q.size()), 1);
          if (rd_got < N_RND && !rempty && $urandom_range(0, 3) != 0) begin
            if (q.size() == 0) begin
              check_eq("rnd_model_nonempty", 0, 1);
              rinc = 1'b0;
              rd_pend = 1'b0;
            end else begin
              rinc = 1'b1;
              rd_exp = q.pop_front();
              rd_pend = 1'b1;
            end
          end else begin
            rinc = 1'b0;
            rd_pend = 1'b0;
          end
          @(posedge rclk); #1;
        end
        rinc = 1'b0;
        check_eq("rnd_rd_done", rd_got, N_RND);
      end
    join
    repeat (6) @(posedge wclk);
    #1;
    check_eq("rnd_model_empty", q.size(), 0);
    check_eq("rnd_woverflow", 32'(woverflow), 0);
    check_eq("rnd_runderflow", 32'(runderflow), 0);
    check_eq("rnd_rempty", 32'(rempty), 1);
    check_eq("rnd_wlevel", 32'(wlevel), 0);
    check_eq("rnd_rlevel", 32'(rlevel), 0);
`endif

    mid_burst_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
